a2d_sched: RTL and testbench
============================

Name: a2d_sched

Overview:
- Round-robin conversion scheduler for the external ADC128S A2D: left load cell, right load cell, steering pot, battery.
- Issues the two-transaction SPI sequence to a shared SPI monarch (`SPI_mnrch`, instantiated by the parent): address, then read.
- Holds the latest 12-bit result for each channel.
- Sits between the SPI monarch and the rider-detect, steer and battery-monitor logic in Segway.

Parameters:
- CH_LFT, 3'd0, ADC channel of left load cell
- CH_RGHT, 3'd4, ADC channel of right load cell
- CH_STEER, 3'd5, ADC channel of steering pot
- CH_BATT, 3'd6, ADC channel of battery
- GAP_CYC, 4, idle clocks between the two SPI transactions (min SS_n high time)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset (synchronized global reset)
- nxt  in  1  request one conversion of the current round-robin channel
- wrt  out  1  one-cycle pulse starting an SPI transaction
- wt_data  out  16  SPI command word
- done  in  1  SPI transaction complete (one-cycle pulse)
- rd_data  in  16  SPI read data, valid when done=1
- busy  out  1  conversion in progress
- conv_done  out  1  one-cycle pulse when a result is latched
- lft_ld  out  12  latest left load cell result
- rght_ld  out  12  latest right load cell result
- steer_pot  out  12  latest steering pot result
- batt  out  12  latest battery result

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0.
  - 2-bit channel pointer ptr=0.
  - pend=0; gap counter=0.
- Channel map:
  - ptr 0→CH_LFT, 1→CH_RGHT, 2→CH_STEER, 3→CH_BATT.
  - wt_data={2'b00, chan[2:0], 11'h000}.
  - wt_data is held stable from the wrt pulse until the next wrt pulse.
- States:
  - IDLE:
    - On nxt or pend: pulse wrt with the command for ptr; clear pend; go to XMIT1.
    - busy=0 only in IDLE.
  - XMIT1: wait for done; on done load gap counter with GAP_CYC-1; go to GAP.
  - GAP:
    - Decrement the counter.
    - At 0: pulse wrt with the same wt_data; go to XMIT2.
  - XMIT2:
    - On done: latch rd_data[11:0] into the register selected by ptr.
    - Pulse conv_done the next cycle.
    - ptr increments, wrapping 3→0.
    - Go to IDLE.
- Latency:
  - wrt goes high the cycle after nxt is sampled.
  - conv_done goes high the cycle after the second done.
  - The result register updates on the same edge conv_done rises, so both are visible together.
- rd_data[15:12] are ignored; no arithmetic on results.
- nxt while busy sets pend; requests collapse to at most one pending (later ones are dropped). The pending request starts one cycle after the return to IDLE.
- done outside XMIT1/XMIT2 is ignored.
- nxt and done in the same cycle in XMIT2: the result is latched and pend is set.
- Reset mid-operation:
  - Immediate return to IDLE; ptr=0.
  - All result registers are cleared; the partially completed conversion is discarded.
- Only non-result registers change outside XMIT2 completion.

Decomposition:
- Shared package `segway_pkg`:
  - typedef enum `a2d_state_t` {IDLE, XMIT1, GAP, XMIT2}.
  - ADC channel localparams (default values of CH_*).
  - Function `a2d_cmd(chan)` that builds wt_data.
- No sub-module; `SPI_mnrch` stays external.
- Roughly 150 lines of RTL.

Test Plan:
- Bench setup: ADC128S_FC model + SPI_mnrch. Model values ld_cell_lft=400, ld_cell_rght=300, steerPot=200, batt=0x8FF.
- Round robin: four nxt pulses, each after conv_done → lft_ld=400, rght_ld=300, steer_pot=200, batt=0x8FF in that order. ptr returns to 0; wt_data sequence 0x0000, 0x2000, 0x2800, 0x3000.
- Timing: after nxt, wrt rises next cycle. Between XMIT1 done and second wrt exactly GAP_CYC clocks. conv_done is 1 cycle wide.
- Queueing: three nxt pulses during one conversion → exactly one extra conversion (rght); no third. busy stays high across both.
- Wrap/refresh: change batt to 0x700, run 8 conversions → batt=0x700, other values unchanged. conv_done count=8.
- Reset mid-op: assert rst_n low while in GAP of channel 1 → outputs all 0, wrt never pulses again. The next nxt after reset converts CH_LFT (wt_data=0x0000).
- Stray done: pulse done in IDLE → no state change, no conv_done, registers unchanged.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared Segway definitions: A2D scheduler states, ADC channel map and SPI command builder.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XMIT1 = 2'd1,
        GAP   = 2'd2,
        XMIT2 = 2'd3
    } a2d_state_t;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    localparam int unsigned GAP_CYC = 4;
    localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
    localparam int unsigned CMD_W   = 16;
    localparam int unsigned RES_W   = 12;

    // ADC128S control word: channel address in bits [13:11]
    function automatic logic [CMD_W-1:0] a2d_cmd(input logic [2:0] chan);
        return {2'b00, chan, 11'h000};
    endfunction

    function automatic logic [2:0] a2d_chan(input logic [1:0] ptr);
        case (ptr)
            2'd0:    return CH_LFT;
            2'd1:    return CH_RGHT;
            2'd2:    return CH_STEER;
            default: return CH_BATT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_sched.sv
// Round-robin ADC128S conversion scheduler driving an external SPI monarch
// (address transaction, idle gap, read transaction) and holding the latest results.
module a2d_sched
    import segway_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] wt_data,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        conv_done,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt
);

    a2d_state_t       state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic             pend, pend_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             wrt_nxt, conv_nxt, busy_nxt, ld_en;
    logic [CMD_W-1:0] wt_nxt;

    // Upper nibble of the SPI read word carries no conversion data
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            pend      <= 1'b0;
            gap_cnt   <= '0;
            wrt       <= 1'b0;
            wt_data   <= '0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            pend      <= pend_nxt;
            gap_cnt   <= gap_cnt_nxt;
            wrt       <= wrt_nxt;
            wt_data   <= wt_nxt;
            busy      <= busy_nxt;
            conv_done <= conv_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        pend_nxt    = pend;
        gap_cnt_nxt = gap_cnt;
        wrt_nxt     = 1'b0;
        wt_nxt      = wt_data;
        conv_nxt    = 1'b0;
        ld_en       = 1'b0;

        case (state)
            IDLE: begin
                if (nxt || pend) begin
                    wrt_nxt   = 1'b1;
                    wt_nxt    = a2d_cmd(a2d_chan(ptr));
                    pend_nxt  = 1'b0;
                    state_nxt = XMIT1;
                end
            end
            XMIT1: begin
                if (nxt) pend_nxt = 1'b1;
                if (done) begin
                    gap_cnt_nxt = GAP_W'(GAP_CYC - 1);
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (nxt) pend_nxt = 1'b1;
                if (gap_cnt == '0) begin
                    wrt_nxt   = 1'b1;
                    state_nxt = XMIT2;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end
            XMIT2: begin
                if (nxt) pend_nxt = 1'b1;
                if (done) begin
                    ld_en     = 1'b1;
                    conv_nxt  = 1'b1;
                    ptr_nxt   = ptr + 2'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A queued request keeps busy asserted through the single IDLE cycle
        busy_nxt = (state_nxt != IDLE) || pend_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else if (ld_en) begin
            case (ptr)
                2'd0:    lft_ld    <= rd_data[RES_W-1:0];
                2'd1:    rght_ld   <= rd_data[RES_W-1:0];
                2'd2:    steer_pot <= rd_data[RES_W-1:0];
                default: batt      <= rd_data[RES_W-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Bench for a2d_sched: ADC/SPI responder, event-level reference model, directed scenarios.
module tb_a2d_sched;

    localparam int GAP_CYC = 4;
    localparam int SPI_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic        wrt, busy, conv_done;
    logic [15:0] wt_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    a2d_sched dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .wt_data(wt_data),
        .done(done), .rd_data(rd_data), .busy(busy), .conv_done(conv_done),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ADC128S stand-in: each read returns the channel addressed by the previous transaction
    logic [11:0] adc[8];
    int          last_chan = 0;
    int          stray_req = 0;
    int          stray_ack = 0;

    initial begin
        int chan;
        forever begin
            @(posedge clk); #1;
            if (rst_n && wrt) begin
                chan = int'(wt_data[13:11]);
                repeat (SPI_LAT) @(posedge clk);
                #1;
                done    = 1'b1;
                rd_data = {4'hA, adc[last_chan]};
                last_chan = chan;
                @(posedge clk); #1;
                done    = 1'b0;
                rd_data = 16'h0;
            end else if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                done    = 1'b1;
                rd_data = 16'hFFFF;
                @(posedge clk); #1;
                done    = 1'b0;
                rd_data = 16'h0;
            end
        end
    end

    // Reference model: request bookkeeping plus timestamps for the second transaction
    int          chans[4] = '{0, 4, 5, 6};
    int          cyc = 0;
    int          m_phase = 0;   // 0 idle, 1 address xfer, 2 gap, 3 read xfer
    int          m_gap_due = 0;
    int          m_ptr = 0;
    bit          m_pend = 0;
    bit          e_wrt = 0;
    bit          e_conv = 0;
    logic [15:0] m_wt = 16'h0;
    logic [11:0] m_res[4] = '{12'h0, 12'h0, 12'h0, 12'h0};

    always @(posedge clk) begin
        cyc++;
        e_wrt  = 0;
        e_conv = 0;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_pend = 0; m_wt = 16'h0;
            for (int i = 0; i < 4; i++) m_res[i] = 12'h0;
        end else if (m_phase == 0) begin
            if (nxt || m_pend) begin
                m_pend  = 0;
                m_phase = 1;
                e_wrt   = 1;
                m_wt    = 16'(chans[m_ptr] * 2048);
            end
        end else begin
            if (nxt) m_pend = 1;
            if (m_phase == 1 && done) begin
                m_phase   = 2;
                m_gap_due = cyc + GAP_CYC;
            end else if (m_phase == 2 && cyc == m_gap_due) begin
                e_wrt   = 1;
                m_phase = 3;
            end else if (m_phase == 3 && done) begin
                m_res[m_ptr] = rd_data[11:0];
                e_conv  = 1;
                m_ptr   = (m_ptr + 1) % 4;
                m_phase = 0;
            end
        end
    end

    int          conv_cnt = 0;
    logic [15:0] wtq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("wrt", 32'(wrt), 32'(e_wrt));
            chk("wt_data", 32'(wt_data), 32'(m_wt));
            chk("busy", 32'(busy), 32'((m_phase != 0) || m_pend));
            chk("conv_done", 32'(conv_done), 32'(e_conv));
            chk("lft_ld", 32'(lft_ld), 32'(m_res[0]));
            chk("rght_ld", 32'(rght_ld), 32'(m_res[1]));
            chk("steer_pot", 32'(steer_pot), 32'(m_res[2]));
            chk("batt", 32'(batt), 32'(m_res[3]));
            if (conv_done) conv_cnt++;
            if (wrt) wtq.push_back(wt_data);
        end
    end

    task automatic pulse_nxt();
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
    endtask

    task automatic wait_conv(input int target);
        for (int k = 0; k < 400 && conv_cnt < target; k++) @(posedge clk);
        chk("conv_reached", 32'(conv_cnt), 32'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrt"}, 32'(wrt), 32'h0);
        chk({tag, "_wt"}, 32'(wt_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_conv"}, 32'(conv_done), 32'h0);
        chk({tag, "_lft"}, 32'(lft_ld), 32'h0);
        chk({tag, "_rght"}, 32'(rght_ld), 32'h0);
        chk({tag, "_steer"}, 32'(steer_pot), 32'h0);
        chk({tag, "_batt"}, 32'(batt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, w0, w1;
        logic [15:0] rr_exp[8];
        rr_exp = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                   16'h2800, 16'h2800, 16'h3000, 16'h3000};
        for (int i = 0; i < 8; i++) adc[i] = 12'h0;
        adc[0] = 12'd400; adc[4] = 12'd300; adc[5] = 12'd200; adc[6] = 12'h8FF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Round robin, first request also pins nxt->wrt latency
        @(posedge clk); #1 nxt = 1'b1;
        @(posedge clk); #1 nxt = 1'b0;
        chk("nxt_to_wrt", 32'(wrt), 32'h1);
        wait_conv(1);
        for (int i = 1; i < 4; i++) begin
            pulse_nxt();
            wait_conv(i + 1);
        end
        chk("rr_lft", 32'(lft_ld), 32'd400);
        chk("rr_rght", 32'(rght_ld), 32'd300);
        chk("rr_steer", 32'(steer_pot), 32'd200);
        chk("rr_batt", 32'(batt), 32'h8FF);
        chk("rr_wt_count", 32'(wtq.size()), 32'd8);
        for (int i = 0; i < 8 && i < wtq.size(); i++)
            chk("rr_wt_seq", 32'(wtq[i]), 32'(rr_exp[i]));

        // Three requests during one conversion collapse to one extra
        base = conv_cnt;
        w0 = wtq.size();
        pulse_nxt();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_nxt();
            @(posedge clk);
        end
        wait_conv(base + 2);
        repeat (60) @(posedge clk);
        chk("queue_convs", 32'(conv_cnt - base), 32'd2);
        chk("queue_wrts", 32'(wtq.size() - w0), 32'd4);
        if (wtq.size() >= w0 + 3) chk("queue_extra_chan", 32'(wtq[w0 + 2]), 32'h2000);

        // Battery refresh across two full laps
        adc[6] = 12'h700;
        base = conv_cnt;
        for (int i = 0; i < 8; i++) begin
            pulse_nxt();
            wait_conv(base + i + 1);
        end
        chk("wrap_convs", 32'(conv_cnt - base), 32'd8);
        chk("wrap_batt", 32'(batt), 32'h700);
        chk("wrap_lft", 32'(lft_ld), 32'd400);
        chk("wrap_rght", 32'(rght_ld), 32'd300);
        chk("wrap_steer", 32'(steer_pot), 32'd200);

        // Stray done while idle
        base = conv_cnt;
        @(posedge clk); #1 stray_req++;
        repeat (10) @(posedge clk);
        chk("stray_convs", 32'(conv_cnt - base), 32'd0);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_batt", 32'(batt), 32'h700);
        chk("stray_lft", 32'(lft_ld), 32'd400);

        // Move pointer to the right load cell, then reset during its gap
        base = conv_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse_nxt();
            wait_conv(base + i + 1);
        end
        pulse_nxt();
        for (int k = 0; k < 100 && m_phase != 2; k++) @(negedge clk);
        chk("reach_gap", 32'(m_phase), 32'd2);
        chk("gap_chan", 32'(wtq[wtq.size() - 1]), 32'h2000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midop");
        @(negedge clk);
        chk("midop_hold_wrt", 32'(wrt), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        w1 = wtq.size();
        base = conv_cnt;
        repeat (20) @(posedge clk);
        chk("no_wrt_after_rst", 32'(wtq.size() - w1), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'h0);
        pulse_nxt();
        wait_conv(base + 1);
        if (wtq.size() > w1) chk("rst_first_chan", 32'(wtq[w1]), 32'h0000);
        chk("rst_lft", 32'(lft_ld), 32'd400);
        chk("rst_rght", 32'(rght_ld), 32'h0);
        chk("rst_batt", 32'(batt), 32'h0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
